cbx_param: RTL and testbench

CBX_PARAM -- requirements
Module: cbx_param

---
 rtl/cbx_param.sv | 159 +++++++++++++++
 tb/tb_cbx_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cbx_param.sv
// cbx_param: connection box for one horizontal channel segment.
// Pass-through tracks are wired straight across. Each grid input pin picks
// one track, or a constant 0, through a select field. A serial shadow chain
// holds the next configuration, and a commit copies it into the active
// selects only when exactly CFG_BITS bits have been shifted since the last
// commit or reset.
// Optional build macro: CBX_REG_IPIN_EN registers ipin_out, adding one cycle
// of latency. Without it, ipin_out is combinational.
module cbx_param #(
    parameter int CHAN_W   = 3,
    parameter int NUM_IPIN = 2
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                ccff_commit,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int SEL_W    = $clog2(2 * CHAN_W + 1);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    // Shift-count states: the counter value is the state encoding source.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFTING = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_OVER     = 2'd3;

    logic [CFG_BITS-1:0] shadow_r;
    logic [CFG_BITS-1:0] active_r;
    logic [CNT_W-1:0]    count_r;
    logic                cfg_valid_r;
    logic                cfg_err_r;
    logic [1:0]          state_s;
    logic [NUM_IPIN-1:0] ipin_s;

    // One track-select decoder.
    // Selects below CHAN_W pick a left track.
    // Selects from CHAN_W to 2*CHAN_W-1 pick a right track.
    // Every other select drives a constant 0.
    function automatic logic sel_bit(input logic [SEL_W-1:0]  sel,
                                     input logic [CHAN_W-1:0] left,
                                     input logic [CHAN_W-1:0] right);
        logic bit_v;
        bit_v = 1'b0;
        for (int k = 0; k < CHAN_W; k++) begin
            if (sel == SEL_W'(k)) begin
                bit_v = left[k];
            end else if (sel == SEL_W'(k + CHAN_W)) begin
                bit_v = right[k];
            end else begin
                bit_v = bit_v;
            end
        end
        return bit_v;
    endfunction

    // Tracks pass straight across; configuration and reset never touch them.
    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    assign ccff_tail = shadow_r[CFG_BITS-1];
    assign cfg_valid = cfg_valid_r;
    assign cfg_err   = cfg_err_r;

    // Classify the saturating shift count into the load state.
    always_comb begin
        state_s = ST_IDLE;
        if (count_r == {CNT_W{1'b0}}) begin
            state_s = ST_IDLE;
        end else if (count_r < CNT_FULL) begin
            state_s = ST_SHIFTING;
        end else if (count_r == CNT_FULL) begin
            state_s = ST_FULL;
        end else begin
            state_s = ST_OVER;
        end
    end

    // Shadow chain, shift counter and commit handling.
    // A commit wins over a shift in the same cycle.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shadow_r    <= {CFG_BITS{1'b0}};
            active_r    <= {CFG_BITS{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            cfg_valid_r <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else if (ccff_commit) begin
            count_r <= {CNT_W{1'b0}};
            case (state_s)
                ST_FULL: begin
                    active_r    <= shadow_r;
                    cfg_valid_r <= 1'b1;
                    cfg_err_r   <= 1'b0;
                end
                default: begin
                    cfg_err_r <= 1'b1;
                end
            endcase
        end else begin
            cfg_err_r <= 1'b0;
            if (ccff_en) begin
                shadow_r <= {shadow_r[CFG_BITS-2:0], ccff_head};
                if (count_r != CNT_SAT) begin
                    count_r <= count_r + CNT_W'(1);
                end else begin
                    count_r <= count_r;
                end
            end else begin
                shadow_r <= shadow_r;
                count_r  <= count_r;
            end
        end
    end

    // Per-pin select decode; pins read 0 until a configuration is active.
    always_comb begin
        ipin_s = {NUM_IPIN{1'b0}};
        for (int i = 0; i < NUM_IPIN; i++) begin
            if (cfg_valid_r) begin
                ipin_s[i] = sel_bit(active_r[i*SEL_W +: SEL_W],
                                    chanx_left_in, chanx_right_in);
            end else begin
                ipin_s[i] = 1'b0;
            end
        end
    end

`ifdef CBX_REG_IPIN_EN
    logic [NUM_IPIN-1:0] ipin_r;

    // Register the pin outputs, which adds one cycle of latency.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            ipin_r <= {NUM_IPIN{1'b0}};
        end else begin
            ipin_r <= ipin_s;
        end
    end

    assign ipin_out = ipin_r;
`else
    assign ipin_out = ipin_s;
`endif

endmodule

// File: tb/tb_cbx_param.sv
// Scoreboard bench for cbx_param at its default parameters.
// Stimulus pushes hand-computed expected outputs into a queue.
// A negedge monitor pops each entry and compares it with the DUT outputs.
module tb_cbx_param;

    logic       prog_clk;
    logic       prog_reset_n;
    logic [2:0] chanx_left_in;
    logic [2:0] chanx_right_in;
    logic       ccff_head;
    logic       ccff_en;
    logic       ccff_commit;
    logic [2:0] chanx_left_out;
    logic [2:0] chanx_right_out;
    logic [1:0] ipin_out;
    logic       ccff_tail;
    logic       cfg_valid;
    logic       cfg_err;

    typedef struct {
        string      name;
        logic [1:0] ipin;
        logic       valid;
        logic       err;
        logic       tail;
        logic [2:0] lout;
        logic [2:0] rout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    cbx_param dut (
        .prog_clk        (prog_clk),
        .prog_reset_n    (prog_reset_n),
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .ccff_head       (ccff_head),
        .ccff_en         (ccff_en),
        .ccff_commit     (ccff_commit),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out),
        .ipin_out        (ipin_out),
        .ccff_tail       (ccff_tail),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Push an expected output vector.
    // The expected pass-through values come from the bench's own drive values.
    task automatic expect_out(input string nm, input logic [1:0] ip,
                              input logic v, input logic e, input logic t);
        exp_t x;
        x.name  = nm;
        x.ipin  = ip;
        x.valid = v;
        x.err   = e;
        x.tail  = t;
        x.lout  = chanx_right_in;
        x.rout  = chanx_left_in;
        exp_q.push_back(x);
    endtask

    // Apply one clock of stimulus.
    // Inputs change just after a negedge, and en/commit drop after the posedge.
    task automatic drive(input logic en, input logic hd, input logic cm,
                         input logic [2:0] l, input logic [2:0] r);
        @(negedge prog_clk);
        #1;
        ccff_en        = en;
        ccff_head      = hd;
        ccff_commit    = cm;
        chanx_left_in  = l;
        chanx_right_in = r;
        @(posedge prog_clk);
        #1;
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
    endtask

    task automatic shift(input logic hd);
        drive(1'b1, hd, 1'b0, chanx_left_in, chanx_right_in);
    endtask

    // Monitor: compare every pending expectation against the DUT outputs.
    always @(negedge prog_clk) begin
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ({ipin_out, cfg_valid, cfg_err, ccff_tail, chanx_left_out, chanx_right_out} !==
                {mon_e.ipin, mon_e.valid, mon_e.err, mon_e.tail, mon_e.lout, mon_e.rout}) begin
                n_miss++;
                $display("FAIL %s: got ipin=%b valid=%b err=%b tail=%b lout=%b rout=%b, want ipin=%b valid=%b err=%b tail=%b lout=%b rout=%b",
                         mon_e.name, ipin_out, cfg_valid, cfg_err, ccff_tail,
                         chanx_left_out, chanx_right_out, mon_e.ipin, mon_e.valid,
                         mon_e.err, mon_e.tail, mon_e.lout, mon_e.rout);
            end
        end
    end

    // Watchdog: guarantees termination.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        prog_reset_n   = 1'b0;
        chanx_left_in  = 3'b000;
        chanx_right_in = 3'b000;
        ccff_head      = 1'b0;
        ccff_en        = 1'b0;
        ccff_commit    = 1'b0;
        #1;
        expect_out("reset_state", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge prog_clk);
        #1;
        prog_reset_n = 1'b1;

        // Short load: five shifts, then a commit, flags an error.
        // Pins stay 0 even though every track is high.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 3'b111, 3'b111);
        expect_out("short_shifted", 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'b111, 3'b111);
        expect_out("short_commit", 2'b00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
        expect_out("short_err_1cyc", 2'b00, 1'b0, 1'b0, 1'b0);

        // Full load: shift 0,1,1,1,0,0 into the shadow.
        // The result gives IPIN0 sel 4 (right[1]) and IPIN1 sel 3 (right[0]).
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        expect_out("full_shift1_tail", 2'b00, 1'b0, 1'b0, 1'b1);
        shift(1'b1);
        shift(1'b1);
        shift(1'b1);
        shift(1'b0);
        shift(1'b0);
        expect_out("full_shift6_tail", 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        expect_out("full_commit", 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b010);
        expect_out("sel4_right1", 2'b01, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b111, 3'b001);
        expect_out("sel3_right0", 2'b10, 1'b1, 1'b0, 1'b0);

        // Over-shift: seven shifts, then a commit, is rejected.
        // The active selects keep their previous values.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        expect_out("over_tail", 2'b00, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b010);
        expect_out("over_commit", 2'b01, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b010);
        expect_out("over_hold_a", 2'b01, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 3'b111, 3'b001);
        expect_out("over_hold_b", 2'b10, 1'b1, 1'b0, 1'b1);

        // Out-of-range select: IPIN0 gets sel 7 and IPIN1 gets sel 2 (left[2]).
        // The shift order is 0,1,0,1,1,1.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        shift(1'b1);
        shift(1'b0);
        shift(1'b1);
        shift(1'b1);
        shift(1'b1);
        expect_out("oor_loaded_tail", 2'b00, 1'b1, 1'b0, 1'b0);
        // Commit with a shift in the same cycle: the commit wins.
        // The shadow stays 010111, so tail stays 0. A shift would have made it 1.
        drive(1'b1, 1'b0, 1'b1, 3'b000, 3'b000);
        expect_out("same_cycle", 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
        expect_out("oor_all_high", 2'b10, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b100, 3'b000);
        expect_out("oor_left2_high", 2'b10, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b011, 3'b111);
        expect_out("oor_left2_low", 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'b011, 3'b111);
        expect_out("idle_commit", 2'b00, 1'b1, 1'b1, 1'b0);

        // Reset mid-shift after three shifts.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 3'b111, 3'b111);
        expect_out("pre_reset", 2'b10, 1'b1, 1'b0, 1'b1);
        @(negedge prog_clk);
        #1;
        prog_reset_n = 1'b0;
        #1;
        expect_out("reset_mid", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        // Partial data was discarded, so three fresh shifts cannot be committed.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 3'b111, 3'b111);
        drive(1'b0, 1'b0, 1'b1, 3'b111, 3'b111);
        expect_out("post_reset_commit", 2'b00, 1'b0, 1'b1, 1'b0);

        @(negedge prog_clk);
        @(negedge prog_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
